// File: rtl/rv_pkg.sv
// Shared RV32I definitions used by the fetch front end.
package rv_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
   localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// DEPTH-entry synchronous FIFO with flush; head is valid whenever count != 0.
module fetch_buffer #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           flush,
   input  logic                           push,
   input  logic [WIDTH-1:0]               push_data,
   input  logic                           pop,
   output logic [WIDTH-1:0]               head,
   output logic [$clog2(DEPTH+1)-1:0]     count
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;

   function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= bump(wr_ptr);
         if (pop)  rd_ptr <= bump(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush && !rst) mem[wr_ptr] <= push_data;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC ownership, credit-limited imem requests,
// instruction buffering toward decode, and redirect flush with response discard.
module if_stage
   import rv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR,
   parameter logic [XLEN-1:0] NOP      = NOP_INSTR,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   input  logic            id_ready,
   output logic            id_valid,
   output logic [XLEN-1:0] pc_to_id,
   output logic [XLEN-1:0] ir
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [XLEN-1:0] fetch_pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   count;
   logic [CW-1:0]   discard;
   logic [CW:0]     credits;
   logic            grant;
   logic            buf_push;
   logic            buf_pop;
   logic [XLEN-1:0] pc_head;
   fetch_entry_t    buf_head;
   fetch_entry_t    buf_in;
   logic            unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc[1:0];

   // Wrong-path responses still occupy the PC FIFO, so in-flight requests are
   // also capped at DEPTH to keep it (and the counters) in range while draining.
   assign credits   = {1'b0, outstanding} + {1'b0, count} - {1'b0, discard};
   assign imem_req  = !rst && !redirect && (credits < (CW+1)'(DEPTH))
                      && (outstanding < CW'(DEPTH));
   assign imem_addr = fetch_pc;
   assign grant     = imem_req && imem_gnt;

   assign id_valid = (count != '0) && !redirect;
   assign pc_to_id = id_valid ? buf_head.pc    : '0;
   assign ir       = id_valid ? buf_head.instr : NOP;

   assign buf_push = imem_rvalid && (discard == '0) && !redirect;
   assign buf_pop  = id_valid && id_ready;
   assign buf_in   = {pc_head, imem_rdata};

   fetch_buffer #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_ibuf (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .push      (buf_push),
      .push_data (buf_in),
      .pop       (buf_pop),
      .head      (buf_head),
      .count     (count)
   );

   fetch_buffer #(
      .DEPTH (DEPTH),
      .WIDTH (XLEN)
   ) u_pc_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (1'b0),
      .push      (grant),
      .push_data (fetch_pc),
      .pop       (imem_rvalid),
      .head      (pc_head),
      .count     (outstanding)
   );

   always_ff @(posedge clk) begin
      if (rst)
         fetch_pc <= {RESET_PC[XLEN-1:2], 2'b00};
      else if (redirect)
         fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (grant)
         fetch_pc <= fetch_pc + XLEN'(4);
   end

   // A response landing in the redirect cycle is dropped regardless of the old
   // discard value, so it is excluded from the new discard count.
   always_ff @(posedge clk) begin
      if (rst)
         discard <= '0;
      else if (redirect)
         discard <= outstanding - CW'(imem_rvalid);
      else if (imem_rvalid && (discard != '0))
         discard <= discard - CW'(1);
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage against a queue-based model of the fetch stage.
module tb_if_stage;

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOPV   = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] pc_to_id;
   logic [31:0] ir;

   if_stage #(
      .RESET_PC (RST_PC),
      .NOP      (NOPV),
      .DEPTH    (DEPTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .id_ready    (id_ready),
      .id_valid    (id_valid),
      .pc_to_id    (pc_to_id),
      .ir          (ir)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   bit mem_hold = 1'b0;
   int lat      = 1;

   // memory side: address and earliest response cycle of each granted request
   logic [31:0] mq_addr[$];
   int          mq_due[$];

   // model: next fetch PC, in-flight requests tagged wrong-path, buffered words
   logic [31:0] m_pc;
   logic [31:0] fly_pc[$];
   bit          fly_wrong[$];
   logic [31:0] buf_pc[$];
   logic [31:0] buf_ir[$];
   logic [31:0] granted[$];

   logic        last_req;
   logic        last_valid;
   logic [31:0] last_addr;
   logic [31:0] last_pc;
   logic [31:0] last_ir;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0) return 32'h0050_0093;
      if (a == 32'h4) return 32'h0010_0113;
      return a ^ 32'hA5A5_0003;
   endfunction

   function automatic int live_count();
      int n = 0;
      foreach (fly_wrong[i]) if (!fly_wrong[i]) n++;
      return n;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = RST_PC;
      fly_pc.delete();
      fly_wrong.delete();
      buf_pc.delete();
      buf_ir.delete();
      mq_addr.delete();
      mq_due.delete();
   endtask

   task automatic step(input bit r, input bit g, input bit rdir,
                       input logic [31:0] rpc, input bit rdy);
      bit          e_req;
      bit          e_valid;
      bit          w;
      logic [31:0] e_pc;
      logic [31:0] e_ir;
      logic [31:0] p;
      rst         = r;
      imem_gnt    = g;
      redirect    = rdir;
      redirect_pc = rpc;
      id_ready    = rdy;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (!r && !mem_hold && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
         imem_rvalid = 1'b1;
         imem_rdata  = mem_word(mq_addr[0]);
      end
      #3;
      e_req   = !r && !rdir && ((live_count() + int'(buf_pc.size())) < int'(DEPTH))
                && (int'(fly_pc.size()) < int'(DEPTH));
      e_valid = (buf_pc.size() > 0) && !rdir;
      e_pc    = e_valid ? buf_pc[0] : 32'h0;
      e_ir    = e_valid ? buf_ir[0] : NOPV;
      last_req   = imem_req;
      last_valid = id_valid;
      last_addr  = imem_addr;
      last_pc    = pc_to_id;
      last_ir    = ir;
      chk("imem_req",  32'(imem_req), 32'(e_req));
      chk("imem_addr", imem_addr, m_pc);
      chk("id_valid",  32'(id_valid), 32'(e_valid));
      chk("pc_to_id",  pc_to_id, e_pc);
      chk("ir",        ir, e_ir);
      if (r) begin
         model_reset();
      end else begin
         if (e_valid && rdy) begin
            void'(buf_pc.pop_front());
            void'(buf_ir.pop_front());
         end
         if (imem_rvalid) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
            if (fly_pc.size() > 0) begin
               p = fly_pc.pop_front();
               w = fly_wrong.pop_front();
               if (!w && !rdir) begin
                  buf_pc.push_back(p);
                  buf_ir.push_back(imem_rdata);
               end
            end
         end
         if (rdir) begin
            buf_pc.delete();
            buf_ir.delete();
            foreach (fly_wrong[i]) fly_wrong[i] = 1'b1;
            m_pc = {rpc[31:2], 2'b00};
         end
         if (e_req && g) begin
            fly_pc.push_back(m_pc);
            fly_wrong.push_back(1'b0);
            mq_addr.push_back(m_pc);
            mq_due.push_back(cyc + lat);
            granted.push_back(m_pc);
            m_pc = m_pc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      mem_hold = 1'b0;
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      granted.delete();
   endtask

   initial begin
      rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
      redirect = 1'b0; redirect_pc = '0; id_ready = 1'b0;
      model_reset();
      @(posedge clk);
      #1;

      // reset values
      do_reset();
      chk("rst_req",   32'(last_req),   32'd0);
      chk("rst_valid", 32'(last_valid), 32'd0);
      chk("rst_ir",    last_ir,         NOPV);
      chk("rst_pc",    last_pc,         32'h0);
      chk("rst_addr",  last_addr,       RST_PC);

      // reset release, 1-cycle memory, decode always ready
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("s1_first_req",  32'(last_req), 32'd1);
      chk("s1_first_addr", last_addr,     32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("s1_first_valid", 32'(last_valid), 32'd1);
      chk("s1_first_pc",    last_pc,         32'h0);
      chk("s1_first_ir",    last_ir,         32'h0050_0093);
      repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("s1_grant0", granted[0], 32'h0);
      chk("s1_grant1", granted[1], 32'h4);
      chk("s1_grant2", granted[2], 32'h8);

      // decode stalled: buffer fills, request drops, head stays stable
      do_reset();
      repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("s2_full_req",   32'(last_req),   32'd0);
      chk("s2_full_valid", 32'(last_valid), 32'd1);
      chk("s2_full_pc",    last_pc,         32'h0);
      chk("s2_full_ir",    last_ir,         32'h0050_0093);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("s2_drain_pc",   last_pc,         32'h4);
      chk("s2_drain_ir",   last_ir,         32'h0010_0113);
      chk("s2_resume_req", 32'(last_req),   32'd1);
      chk("s2_resume_addr", last_addr,      32'h8);
      repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

      // redirect with two requests outstanding
      do_reset();
      mem_hold = 1'b1;
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h100, 1'b1);
      chk("s3_redir_req", 32'(last_req), 32'd0);
      mem_hold = 1'b0;
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("s3_drain_req", 32'(last_req), 32'd0);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("s3_new_req",  32'(last_req), 32'd1);
      chk("s3_new_addr", last_addr,     32'h100);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("s3_valid", 32'(last_valid), 32'd1);
      chk("s3_pc",    last_pc,         32'h100);
      chk("s3_ir",    last_ir,         32'hA5A5_0103);
      repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

      // second redirect while the first discard drain is pending
      do_reset();
      mem_hold = 1'b1;
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h100, 1'b1);
      granted.delete();
      step(1'b0, 1'b1, 1'b1, 32'h300, 1'b1);
      mem_hold = 1'b0;
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("s3b_req",  32'(last_req), 32'd1);
      chk("s3b_addr", last_addr,     32'h300);
      repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("s3b_grant0", granted[0], 32'h300);

      // redirect coinciding with a response and a ready decode
      do_reset();
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
      chk("s4_redir_valid", 32'(last_valid), 32'd0);
      chk("s4_redir_ir",    last_ir,         NOPV);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("s4_after_valid", 32'(last_valid), 32'd0);
      chk("s4_after_req",   32'(last_req),   32'd1);
      chk("s4_after_addr",  last_addr,       32'h200);
      repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

      // unaligned redirect target near the top of the address space
      do_reset();
      step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("s5_addr_top", last_addr, 32'hFFFF_FFFC);
      chk("s5_req_top",  32'(last_req), 32'd1);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("s5_addr_wrap", last_addr, 32'h0);
      chk("s5_req_wrap",  32'(last_req), 32'd1);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("s5_pc_top", last_pc, 32'hFFFF_FFFC);
      repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

      // reset pulse with a full buffer
      do_reset();
      repeat (5) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("s6_rst_req",   32'(last_req),   32'd0);
      chk("s6_rst_valid", 32'(last_valid), 32'd0);
      chk("s6_rst_ir",    last_ir,         NOPV);
      chk("s6_rst_pc",    last_pc,         32'h0);
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("s6_restart_req",  32'(last_req), 32'd1);
      chk("s6_restart_addr", last_addr,     RST_PC);
      repeat (4) step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
